// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and the pending-result payload.
package mult_div_unit_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  // Result captured at start; we=0 suppresses write-back (divide by zero).
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } mdu_result_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_md_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || is_div_op(op);
  endfunction

endpackage

// File: rtl/mult_div_unit_latency_counter.sv
// Fixed-latency sequencer: loads a cycle count, runs it down and flags the
// final busy cycle so the top can commit its pending result.
module mult_div_unit_latency_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             done_c
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           state, state_nx;
  logic [CNT_W-1:0] count, count_nx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    done_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          state_nx = ST_BUSY;
          count_nx = load_val;
        end
      end
      ST_BUSY: begin
        // Last busy cycle: the commit edge also returns the unit to idle.
        if (count == CNT_W'(1)) begin
          done_c   = 1'b1;
          state_nx = ST_IDLE;
          count_nx = '0;
        end else begin
          count_nx = count - CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        count_nx = '0;
      end
    endcase
  end

  assign busy = (state == ST_BUSY);

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the EX stage: computes the result at start,
// holds it pending for a fixed latency, then commits it to HI/LO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [XLEN-1:0]   hi_q, lo_q;
  mdu_result_t       pend_q;
  mdu_result_t       res_c;
  logic              md_start_c;
  logic              done_c;
  logic [CNT_W-1:0]  load_val_c;

  logic [2*XLEN-1:0] a_sx_c, b_sx_c, a_zx_c, b_zx_c;
  logic [2*XLEN-1:0] prod_s_c, prod_u_c;
  logic [XLEN-1:0]   a_mag_c, b_mag_c, b_mag_safe_c, b_safe_c;
  logic [XLEN-1:0]   q_mag_c, r_mag_c, q_u_c, r_u_c;
  logic              b_zero_c;

  assign md_start_c = start && !busy && is_md_op(op);
  assign load_val_c = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // Low 64 bits of a product of extended operands give both signed and unsigned forms.
  always_comb begin
    a_sx_c   = {{XLEN{a[XLEN-1]}}, a};
    b_sx_c   = {{XLEN{b[XLEN-1]}}, b};
    a_zx_c   = {{XLEN{1'b0}}, a};
    b_zx_c   = {{XLEN{1'b0}}, b};
    prod_s_c = a_sx_c * b_sx_c;
    prod_u_c = a_zx_c * b_zx_c;
  end

  // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow corner.
  always_comb begin
    b_zero_c     = (b == '0);
    a_mag_c      = a[XLEN-1] ? (~a + XLEN'(1)) : a;
    b_mag_c      = b[XLEN-1] ? (~b + XLEN'(1)) : b;
    b_mag_safe_c = b_zero_c ? XLEN'(1) : b_mag_c;
    b_safe_c     = b_zero_c ? XLEN'(1) : b;
    q_mag_c      = a_mag_c / b_mag_safe_c;
    r_mag_c      = a_mag_c % b_mag_safe_c;
    q_u_c        = a / b_safe_c;
    r_u_c        = a % b_safe_c;
  end

  always_comb begin
    res_c = '0;
    case (op)
      MDU_MULT: begin
        res_c.we = 1'b1;
        res_c.hi = prod_s_c[2*XLEN-1:XLEN];
        res_c.lo = prod_s_c[XLEN-1:0];
      end
      MDU_MULTU: begin
        res_c.we = 1'b1;
        res_c.hi = prod_u_c[2*XLEN-1:XLEN];
        res_c.lo = prod_u_c[XLEN-1:0];
      end
      MDU_DIV: begin
        res_c.we = !b_zero_c;
        res_c.lo = (a[XLEN-1] ^ b[XLEN-1]) ? (~q_mag_c + XLEN'(1)) : q_mag_c;
        res_c.hi = a[XLEN-1] ? (~r_mag_c + XLEN'(1)) : r_mag_c;
      end
      MDU_DIVU: begin
        res_c.we = !b_zero_c;
        res_c.lo = q_u_c;
        res_c.hi = r_u_c;
      end
      default: res_c = '0;
    endcase
  end

  mult_div_unit_latency_counter #(
    .CNT_W (CNT_W)
  ) u_latency_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (md_start_c),
    .load_val (load_val_c),
    .busy     (busy),
    .done_c   (done_c)
  );

  // HI/LO only change on commit or on an idle-cycle move-to; busy masks all ops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      pend_q <= '0;
    end else if (done_c) begin
      if (pend_q.we) begin
        hi_q <= pend_q.hi;
        lo_q <= pend_q.lo;
      end
      pend_q <= '0;
    end else if (!busy) begin
      if (md_start_c) begin
        pend_q <= res_c;
      end else if (op == MDU_MTHI) begin
        hi_q <= a;
      end else if (op == MDU_MTLO) begin
        lo_q <= a;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios then random
// traffic, every cycle compared against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pwe;
  int          m_left;

  mult_div_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic compute(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rhi, output logic [31:0] rlo, output logic we);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    we = 1'b1;
    rhi = 32'd0;
    rlo = 32'd0;
    case (o)
      3'd1: begin up = longint'(sx * sy); rhi = up[63:32]; rlo = up[31:0]; end
      3'd2: begin up = ux * uy;           rhi = up[63:32]; rlo = up[31:0]; end
      3'd3: begin
        if (y == 32'd0) we = 1'b0;
        else begin sq = sx / sy; sr = sx % sy; rlo = 32'(sq); rhi = 32'(sr); end
      end
      default: begin
        if (y == 32'd0) we = 1'b0;
        else begin rlo = 32'(ux / uy); rhi = 32'(ux % uy); end
      end
    endcase
  endtask

  task automatic model_edge(input logic rs, input logic st, input logic [2:0] o,
                            input logic [31:0] x, input logic [31:0] y);
    if (!rs) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_pwe = 0; m_phi = 0; m_plo = 0;
    end else if (m_left > 0) begin
      if (m_left == 1 && m_pwe) begin m_hi = m_phi; m_lo = m_plo; end
      m_left = m_left - 1;
    end else if (st && o >= 3'd1 && o <= 3'd4) begin
      compute(o, x, y, m_phi, m_plo, m_pwe);
      m_left = (o >= 3'd3) ? DIV_N : MULT_N;
    end else if (o == 3'd5) begin
      m_hi = x;
    end else if (o == 3'd6) begin
      m_lo = x;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs, then compare outputs against the model.
  task automatic cyc(input logic rs, input logic st, input logic [2:0] o,
                     input logic [31:0] x, input logic [31:0] y);
    reset = rs; start = st; op = o; a = x; b = y;
    @(posedge clk);
    model_edge(rs, st, o, x, y);
    #1;
    check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwe = 0; m_left = 0;

    cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    cyc(1'b0, 1'b1, 3'd1, 32'd7, 32'd9);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);

    // mult -3 * 5
    cyc(1'b1, 1'b1, 3'd1, 32'hFFFF_FFFD, 32'd5);
    check("mult_busy0", {31'd0, busy}, 32'd1);
    idle(4);
    check("mult_busy4", {31'd0, busy}, 32'd1);
    idle(1);
    check("mult_done", {31'd0, busy}, 32'd0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);

    // multu max * max; hi/lo hold old value while busy
    cyc(1'b1, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(4);
    check("multu_hold", lo, 32'hFFFF_FFF1);
    idle(1);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // div -7 / 2, then divu 7 / 2
    cyc(1'b1, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
    idle(DIV_N);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b1, 3'd4, 32'd7, 32'd2);
    idle(DIV_N);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    // mthi without start, then divide by zero keeps hi/lo
    cyc(1'b1, 1'b0, 3'd5, 32'h1234_5678, 32'd0);
    check("mthi", hi, 32'h1234_5678);
    cyc(1'b1, 1'b1, 3'd4, 32'd55, 32'd0);
    idle(DIV_N - 1);
    check("dz_busy", {31'd0, busy}, 32'd1);
    idle(1);
    check("dz_hi", hi, 32'h1234_5678);
    check("dz_lo", lo, 32'd3);

    // ops issued while busy are ignored
    cyc(1'b1, 1'b1, 3'd1, 32'd3, 32'd4);
    cyc(1'b1, 1'b1, 3'd4, 32'd9, 32'd3);
    cyc(1'b1, 1'b0, 3'd6, 32'hAAAA_5555, 32'd0);
    idle(MULT_N - 2);
    check("ign_lo", lo, 32'd12);
    check("ign_hi", hi, 32'd0);

    // signed overflow corner and an out-of-range op
    cyc(1'b1, 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(DIV_N);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);
    cyc(1'b1, 1'b1, 3'd7, 32'h5A5A_5A5A, 32'd1);
    check("op7_busy", {31'd0, busy}, 32'd0);

    // reset mid-divide discards the pending result
    cyc(1'b1, 1'b1, 3'd4, 32'd100, 32'd7);
    idle(3);
    cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    idle(DIV_N + 2);
    check("no_late_hi", hi, 32'd0);
    check("no_late_lo", lo, 32'd0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      logic        rrs;
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 15) == 0) ra = 32'h8000_0000;
      rrs = ($urandom_range(0, 63) != 0);
      cyc(rrs, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
